// File: rtl/phy_rx_pkg.sv
// Shared constants and state encodings for the two-lane PHY receive path.
package phy_rx_pkg;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         LOCK_COUNT = 4;

  typedef enum logic {
    ALIGN  = 1'b0,
    LOCKED = 1'b1
  } lane_state_e;

  typedef enum logic {
    EXPECT0 = 1'b0,
    EXPECT1 = 1'b1
  } ustripe_state_e;

endpackage

// File: rtl/phy_rx_lane.sv
// One receive lane: deserializer, comma alignment/lock, byte-to-word packer
// and a single-word holding register with its full flag.
module rx_lane
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = phy_rx_pkg::COMMA,
  parameter int         LOCK_COUNT = phy_rx_pkg::LOCK_COUNT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  input  logic        clear,
  output logic [31:0] word,
  output logic        full,
  output logic        locked,
  output logic        err
);

  lane_state_e state_q, state_nx;
  logic [7:0]  sr;
  logic [7:0]  sr_nx;
  logic [2:0]  bit_cnt;
  logic [3:0]  comma_cnt, cnt_nx;
  logic [1:0]  byte_cnt;
  logic [23:0] pack;
  logic        bit_rst;
  logic        boundary;
  logic        is_comma;

  // Byte decisions look at the shift register including the bit arriving now.
  assign sr_nx    = {sr[6:0], data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign is_comma = (sr_nx == COMMA);
  assign locked   = (state_q == LOCKED);

  always_comb begin
    state_nx = state_q;
    cnt_nx   = comma_cnt;
    bit_rst  = 1'b0;
    if (state_q == ALIGN) begin
      if (comma_cnt == 4'd0) begin
        if (is_comma) begin
          cnt_nx  = 4'd1;
          bit_rst = 1'b1;
        end
      end else if (boundary) begin
        cnt_nx = is_comma ? comma_cnt + 4'd1 : 4'd0;
      end
      if (cnt_nx != 4'd0 && cnt_nx >= 4'(LOCK_COUNT))
        state_nx = LOCKED;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state_q <= ALIGN;
    else        state_q <= state_nx;
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      byte_cnt  <= '0;
      pack      <= '0;
      word      <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sr        <= sr_nx;
      bit_cnt   <= bit_rst ? 3'd0 : bit_cnt + 3'd1;
      comma_cnt <= cnt_nx;
      err       <= 1'b0;
      if (clear) full <= 1'b0;
      if (locked && boundary) begin
        if (is_comma) begin
          // Idle inside a word: the partial word is lost.
          if (byte_cnt != 2'd0) err <= 1'b1;
          byte_cnt <= 2'd0;
        end else if (byte_cnt == 2'd3) begin
          byte_cnt <= 2'd0;
          if (full && !clear) begin
            err <= 1'b1;
          end else begin
            word <= {pack, sr_nx};
            full <= 1'b1;
          end
        end else begin
          pack     <= {pack[15:0], sr_nx};
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/phy_rx.sv
// Two-lane PHY receiver top: lane instances, un-striper FSM and output registers.
module phy_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = phy_rx_pkg::COMMA,
  parameter int         LOCK_COUNT = phy_rx_pkg::LOCK_COUNT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in_0,
  input  logic        data_in_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active_out,
  output logic        error_out
);

  logic [31:0]    word0, word1;
  logic           full0, full1;
  logic           locked0, locked1;
  logic           err0, err1;
  logic           clear0, clear1;
  logic           emit;
  logic [31:0]    emit_word;
  ustripe_state_e state_q, state_nx;

  rx_lane #(.COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT)) u_lane0 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in_0),
    .clear   (clear0),
    .word    (word0),
    .full    (full0),
    .locked  (locked0),
    .err     (err0)
  );

  rx_lane #(.COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT)) u_lane1 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in_1),
    .clear   (clear1),
    .word    (word1),
    .full    (full1),
    .locked  (locked1),
    .err     (err1)
  );

  // Lane 0 word always goes out before the matching lane 1 word.
  always_comb begin
    state_nx  = state_q;
    emit      = 1'b0;
    emit_word = word0;
    clear0    = 1'b0;
    clear1    = 1'b0;
    if (!active_out) begin
      state_nx = EXPECT0;
      clear0   = 1'b1;
      clear1   = 1'b1;
    end else if (state_q == EXPECT0) begin
      if (full0) begin
        emit     = 1'b1;
        clear0   = 1'b1;
        state_nx = EXPECT1;
      end
    end else if (full1) begin
      emit      = 1'b1;
      emit_word = word1;
      clear1    = 1'b1;
      state_nx  = EXPECT0;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state_q <= EXPECT0;
    else        state_q <= state_nx;
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      active_out <= locked0 & locked1;
      valid_out  <= emit;
      error_out  <= err0 | err1;
      if (emit) data_out <= emit_word;
    end
  end

endmodule

// File: tb/tb_phy_rx.sv
// Bench for phy_rx: byte-level lane streams, expected output trace built from
// the framing/lock/un-striping rules, compared every cycle.
module tb_phy_rx;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         LOCK_COUNT = 4;
  localparam int         MAXT       = 2048;
  localparam int         MAXB       = 256;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b0;
  logic        data_in_0 = 1'b0;
  logic        data_in_1 = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active_out;
  logic        error_out;

  phy_rx #(.COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active_out (active_out),
    .error_out  (error_out)
  );

  always #5 clk_32f = ~clk_32f;

  int n_chk = 0;
  int n_err = 0;

  // stimulus: per-lane byte lists and bit offsets
  logic [7:0]  lb   [0:1][0:MAXB-1];
  int          nb   [0:1];
  int          off  [0:1];
  logic        bits [0:1][0:MAXT-1];
  int          tlen;

  // reference: per-lane events and expected outputs after each edge
  logic        wc   [0:1][0:MAXT-1];
  logic [31:0] wv   [0:1][0:MAXT-1];
  logic        fe   [0:1][0:MAXT-1];
  int          lk   [0:1];
  logic        ev   [0:MAXT-1];
  logic [31:0] ed   [0:MAXT-1];
  logic        ea   [0:MAXT-1];
  logic        ee   [0:MAXT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic add(input int l, input logic [7:0] v);
    lb[l][nb[l]] = v;
    nb[l]++;
  endtask

  task automatic add_word(input int l, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) add(l, w[8*i +: 8]);
  endtask

  task automatic add_commas(input int l, input int n);
    for (int i = 0; i < n; i++) add(l, COMMA);
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255)); while (v == COMMA);
    return v;
  endfunction

  task automatic new_scn(input int o0, input int o1);
    nb[0] = 0; nb[1] = 0;
    off[0] = o0; off[1] = o1;
  endtask

  // Serialize the byte lists and derive the expected output trace.
  task automatic prepare();
    int run, pend, e, last_e;
    bit lock_l;
    logic [31:0] acc, last;
    logic a, st, v, ov;
    logic f [0:1];
    logic [31:0] h [0:1];
    logic clr [0:1];
    logic [7:0] bv;

    tlen = 0;
    for (int l = 0; l < 2; l++)
      if (off[l] + 8 * nb[l] > tlen) tlen = off[l] + 8 * nb[l];
    tlen += 48;
    for (int l = 0; l < 2; l++)
      while (off[l] + 8 * nb[l] < tlen) add(l, COMMA);

    for (int l = 0; l < 2; l++) begin
      for (int t = 0; t < MAXT; t++) begin
        bits[l][t] = 1'b0; wc[l][t] = 1'b0; wv[l][t] = '0; fe[l][t] = 1'b0;
      end
      for (int k = 0; k < nb[l]; k++) begin
        bv = lb[l][k];
        for (int i = 0; i < 8; i++)
          if (off[l] + 8 * k + i < MAXT) bits[l][off[l] + 8 * k + i] = bv[7 - i];
      end
      // lock after LOCK_COUNT consecutive commas, then bytes pack into words
      lk[l] = MAXT; run = 0; lock_l = 0; pend = 0; acc = '0;
      for (int k = 0; k < nb[l]; k++) begin
        e  = off[l] + 8 * k + 7;
        bv = lb[l][k];
        if (e >= tlen) break;
        if (!lock_l) begin
          run = (bv == COMMA) ? run + 1 : 0;
          if (run == LOCK_COUNT) begin lock_l = 1; lk[l] = e; end
        end else if (bv == COMMA) begin
          if (pend != 0) fe[l][e] = 1'b1;
          pend = 0;
        end else begin
          acc = {acc[23:0], bv};
          pend++;
          if (pend == 4) begin wc[l][e] = 1'b1; wv[l][e] = acc; pend = 0; end
        end
      end
    end

    for (int t = 0; t < MAXT; t++) ee[t] = 1'b0;
    a = 0; st = 0; last = '0;
    f[0] = 0; f[1] = 0; h[0] = '0; h[1] = '0;
    last_e = tlen;
    for (int t = 0; t < last_e; t++) begin
      clr[0] = !a || (st == 1'b0 && f[0]);
      clr[1] = !a || (st == 1'b1 && f[1]);
      v = 0;
      if (a && st == 1'b0 && f[0]) begin v = 1; last = h[0]; st = 1; end
      else if (a && st == 1'b1 && f[1]) begin v = 1; last = h[1]; st = 0; end
      if (!a) st = 0;
      for (int l = 0; l < 2; l++) begin
        ov = wc[l][t] && f[l] && !clr[l];
        if (wc[l][t] && !ov) begin f[l] = 1; h[l] = wv[l][t]; end
        else if (clr[l]) f[l] = 0;
        if (t + 1 < MAXT && (fe[l][t] || ov)) ee[t + 1] = 1'b1;
      end
      ea[t] = (t > lk[0]) && (t > lk[1]);
      ev[t] = v;
      ed[t] = last;
      a = ea[t];
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; data_in_0 = 1'b0; data_in_1 = 1'b0;
    repeat (2) @(negedge clk_32f);
    chk("rst_valid",  32'(valid_out),  32'd0);
    chk("rst_active", 32'(active_out), 32'd0);
    chk("rst_error",  32'(error_out),  32'd0);
    chk("rst_data",   data_out,        32'd0);
  endtask

  // Drive bit e before edge e; outputs after edge e are sampled at the next negedge.
  task automatic run(input int abort_at);
    @(negedge clk_32f);
    reset = 1'b1;
    data_in_0 = bits[0][0]; data_in_1 = bits[1][0];
    for (int e = 1; e <= tlen; e++) begin
      @(negedge clk_32f);
      chk($sformatf("valid@%0d", e - 1),  32'(valid_out),  32'(ev[e - 1]));
      chk($sformatf("data@%0d", e - 1),   data_out,        ed[e - 1]);
      chk($sformatf("active@%0d", e - 1), 32'(active_out), 32'(ea[e - 1]));
      chk($sformatf("error@%0d", e - 1),  32'(error_out),  32'(ee[e - 1]));
      if (e == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid",  32'(valid_out),  32'd0);
        chk("midrst_active", 32'(active_out), 32'd0);
        chk("midrst_error",  32'(error_out),  32'd0);
        chk("midrst_data",   data_out,        32'd0);
        return;
      end
      if (e < tlen) begin
        data_in_0 = bits[0][e];
        data_in_1 = bits[1][e];
      end
    end
  endtask

  initial begin
    int n;

    // idle lock, lane 1 three bits late
    do_reset();
    new_scn(0, 3);
    add_commas(0, 10); add_commas(1, 10);
    prepare();
    run(-1);

    // aligned word round trip
    do_reset();
    new_scn(0, 0);
    add_commas(0, 6); add_word(0, 32'h01234567);
    add_commas(1, 6); add_word(1, 32'h89ABCDEF);
    prepare();
    run(-1);

    // lane 1 lags by 20 bits
    do_reset();
    new_scn(0, 20);
    add_commas(0, 6); add_word(0, 32'h01234567);
    add_commas(1, 6); add_word(1, 32'h89ABCDEF);
    prepare();
    run(-1);

    // framing error on lane 0, then a good word pair
    do_reset();
    new_scn(0, 0);
    add_commas(0, 6); add(0, 8'h11); add(0, 8'h22); add(0, COMMA); add_word(0, 32'hAABBCCDD);
    add_commas(1, 9); add_word(1, 32'h12345678);
    prepare();
    run(-1);

    // overrun: lane 1 idle while lane 0 keeps sending
    do_reset();
    new_scn(0, 0);
    add_commas(0, 6);
    add_word(0, 32'h0A0B0C0D); add_word(0, 32'h1A1B1C1D); add_word(0, 32'h2A2B2C2D);
    add_commas(1, 6);
    prepare();
    run(-1);

    // reset after two data bytes of the first word, then a clean relock
    do_reset();
    new_scn(0, 0);
    add_commas(0, 6); add_word(0, 32'h01234567);
    add_commas(1, 6); add_word(1, 32'h89ABCDEF);
    prepare();
    run(68);
    do_reset();
    prepare();
    run(-1);

    // randomized traffic with random offsets and skew
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n = $urandom_range(0, 7);
      new_scn(n, n + $urandom_range(0, 24));
      for (int l = 0; l < 2; l++) begin
        add_commas(l, 6);
        for (int k = 0; k < 5; k++) begin
          case ($urandom_range(0, 3))
            0: add(l, COMMA);
            3: begin
              n = $urandom_range(1, 3);
              for (int i = 0; i < n; i++) add(l, rnd_byte());
              add(l, COMMA);
            end
            default: for (int i = 0; i < 4; i++) add(l, rnd_byte());
          endcase
        end
      end
      prepare();
      run(-1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
